// File: rtl/nfc_cmd_sched.sv
// Two-requester round-robin command scheduler in front of the NAND flash controller.
// Optional command watchdog enabled by defining NFC_SCHED_WDT_EN.
module nfc_cmd_sched #(
    parameter int CMD_W      = 33,
    parameter int MEM_DEPTH  = 128,
    parameter int WDT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_vld,
    input  logic [CMD_W-1:0] req0_cmd,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [CMD_W-1:0] req1_cmd,
    output logic             req1_rdy,
    output logic             cmp_vld,
    output logic             cmp_id,
    output logic             cmp_err,
    output logic [CMD_W-1:0] nfc_cmd,
    output logic             nfc_start,
    input  logic             nfc_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        IDLE     = 2'd1,
        BUSY     = 2'd2
    } state_t;

    localparam logic [7:0] MEM_LIM = 8'(MEM_DEPTH);

    state_t           state_q, state_d;
    logic [1:0]       full_q;
    logic [1:0]       pend_q;
    logic [CMD_W-1:0] slot0_q, slot1_q;
    logic [CMD_W-1:0] cmd_q;
    logic             owner_q;
    logic             issue, gnt;
    logic             done_evt, wdt_evt, wdt_hit;
    logic             acc0, acc1, bad0, bad1;
    logic [1:0]       pool;

    // Low 14 bits carry mem address and length; the sum is 8 bits wide.
    function automatic logic cmd_bad(input logic [13:0] f);
        logic [7:0] s;
        s = {1'b0, f[13:7]} + {1'b0, f[6:0]};
        return (f[6:0] == 7'd0) || (s > MEM_LIM);
    endfunction

    assign acc0 = req0_vld & req0_rdy;
    assign acc1 = req1_vld & req1_rdy;
    assign bad0 = cmd_bad(req0_cmd[13:0]);
    assign bad1 = cmd_bad(req1_cmd[13:0]);
    assign pool = pend_q | {acc1 & bad1, acc0 & bad0};

    assign req0_rdy  = ~full_q[0] & ~(|pend_q);
    assign req1_rdy  = ~full_q[1] & ~(|pend_q);
    assign nfc_start = issue;
    assign nfc_cmd   = issue ? (gnt ? slot1_q : slot0_q) : cmd_q;
    assign busy      = (state_q == BUSY);

`ifdef NFC_SCHED_WDT_EN
    logic [15:0] wdt_q;

    // Watchdog counts BUSY cycles, restarting on every issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdt_q <= '0;
        else if (issue)
            wdt_q <= '0;
        else if (state_q == BUSY)
            wdt_q <= wdt_q + 16'd1;
    end

    assign wdt_hit = (wdt_q == 16'(WDT_CYCLES - 1));
`else
    logic unused_wdt;
    assign unused_wdt = |WDT_CYCLES;
    assign wdt_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= WAIT_RDY;
        else
            state_q <= state_d;
    end

    // Next state, grant selection and completion events.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        gnt      = 1'b0;
        done_evt = 1'b0;
        wdt_evt  = 1'b0;
        case (state_q)
            WAIT_RDY: begin
                if (nfc_done)
                    state_d = IDLE;
            end
            IDLE: begin
                if (|full_q) begin
                    issue   = 1'b1;
                    gnt     = (full_q == 2'b11) ? ~owner_q : full_q[1];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (nfc_done) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end else if (wdt_hit) begin
                    wdt_evt = 1'b1;
                    state_d = WAIT_RDY;
                end
            end
            default: state_d = WAIT_RDY;
        endcase
    end

    // Holding slots: fill on a valid accept, free on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 2'b00;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            if (acc0 && !bad0) begin
                full_q[0] <= 1'b1;
                slot0_q   <= req0_cmd;
            end else if (issue && !gnt) begin
                full_q[0] <= 1'b0;
            end
            if (acc1 && !bad1) begin
                full_q[1] <= 1'b1;
                slot1_q   <= req1_cmd;
            end else if (issue && gnt) begin
                full_q[1] <= 1'b0;
            end
        end
    end

    // Issued command and its owner (owner also drives round-robin).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= '0;
            owner_q <= 1'b1;
        end else if (issue) begin
            cmd_q   <= gnt ? slot1_q : slot0_q;
            owner_q <= gnt;
        end
    end

    // Completions: done/timeout first, then held rejects, port 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_vld <= 1'b0;
            cmp_id  <= 1'b0;
            cmp_err <= 1'b0;
            pend_q  <= 2'b00;
        end else if (done_evt || wdt_evt) begin
            cmp_vld <= 1'b1;
            cmp_id  <= owner_q;
            cmp_err <= wdt_evt;
            pend_q  <= pool;
        end else if (|pool) begin
            cmp_vld <= 1'b1;
            cmp_id  <= ~pool[0];
            cmp_err <= 1'b1;
            pend_q  <= pool[0] ? (pool & 2'b10) : 2'b00;
        end else begin
            cmp_vld <= 1'b0;
            cmp_id  <= 1'b0;
            cmp_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nfc_cmd_sched.sv
// Directed self-checking bench for nfc_cmd_sched.
// Inputs change and outputs are sampled just after the falling edge.
module tb_nfc_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [32:0] req0_cmd, req1_cmd;
    logic        req0_rdy, req1_rdy;
    logic        cmp_vld, cmp_id, cmp_err;
    logic [32:0] nfc_cmd;
    logic        nfc_start, nfc_done, busy;

    int n_tests = 0;
    int n_fail  = 0;

    nfc_cmd_sched #(.WDT_CYCLES(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_vld (req0_vld),
        .req0_cmd (req0_cmd),
        .req0_rdy (req0_rdy),
        .req1_vld (req1_vld),
        .req1_cmd (req1_cmd),
        .req1_rdy (req1_rdy),
        .cmp_vld  (cmp_vld),
        .cmp_id   (cmp_id),
        .cmp_err  (cmp_err),
        .nfc_cmd  (nfc_cmd),
        .nfc_start(nfc_start),
        .nfc_done (nfc_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle and return single-cycle inputs to idle.
    task automatic tick();
        @(negedge clk);
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        nfc_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_cmd = '0;
        req1_cmd = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({req0_rdy, req1_rdy} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_rdy got %b exp 11", {req0_rdy, req1_rdy});
        end
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, nfc_start, busy, nfc_cmd} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outs got %b%b%b%b%b %h exp all 0",
                     cmp_vld, cmp_id, cmp_err, nfc_start, busy, nfc_cmd);
        end
    endtask

    task automatic test_basic();
        logic [32:0] w;
        w = {1'b0, 18'h00010, 7'h00, 7'd64};
        tick(); nfc_done = 1'b1; #1;
        tick(); req0_vld = 1'b1; req0_cmd = w; #1;
        n_tests++;
        if (nfc_start !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_early_start got %b exp 0", nfc_start);
        end
        tick(); #1;
        n_tests++;
        if ({nfc_start, req0_rdy, nfc_cmd} !== {1'b1, 1'b0, w}) begin
            n_fail++;
            $display("FAIL basic_issue got %b %b %h exp 1 0 %h",
                     nfc_start, req0_rdy, nfc_cmd, w);
        end
        tick(); #1;
        n_tests++;
        if ({busy, nfc_start, req0_rdy, nfc_cmd} !== {3'b101, w}) begin
            n_fail++;
            $display("FAIL basic_busy got %b%b%b %h exp 101 %h",
                     busy, nfc_start, req0_rdy, nfc_cmd, w);
        end
        repeat (48) tick();
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_cmp got %b%b%b%b exp 1000",
                     cmp_vld, cmp_id, cmp_err, busy);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, nfc_cmd} !== {1'b0, w}) begin
            n_fail++;
            $display("FAIL idle_done_ignored got %b %h exp 0 %h",
                     cmp_vld, nfc_cmd, w);
        end
    endtask

    task automatic test_reject();
        logic [32:0] rb;
        rb = {1'b0, 18'h00007, 7'h60, 7'd32};
        tick(); req1_vld = 1'b1; req1_cmd = {1'b0, 18'h5, 7'h10, 7'd0}; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, nfc_start, req1_rdy} !== 5'b11101) begin
            n_fail++;
            $display("FAIL reject_len0 got %b%b%b%b%b exp 11101",
                     cmp_vld, cmp_id, cmp_err, nfc_start, req1_rdy);
        end
        tick(); req1_vld = 1'b1; req1_cmd = {1'b0, 18'h6, 7'h70, 7'd32}; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, nfc_start} !== 4'b1110) begin
            n_fail++;
            $display("FAIL reject_range got %b%b%b%b exp 1110",
                     cmp_vld, cmp_id, cmp_err, nfc_start);
        end
        tick(); req1_vld = 1'b1; req1_cmd = rb; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, nfc_start, nfc_cmd} !== {2'b01, rb}) begin
            n_fail++;
            $display("FAIL range_edge_ok got %b%b %h exp 01 %h",
                     cmp_vld, nfc_start, nfc_cmd, rb);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err} !== 3'b110) begin
            n_fail++;
            $display("FAIL range_edge_cmp got %b%b%b exp 110",
                     cmp_vld, cmp_id, cmp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] r0, r1, r2, r3, r4;
        r0 = {1'b1, 18'h00001, 7'h00, 7'd8};
        r1 = {1'b1, 18'h00002, 7'h10, 7'd8};
        r2 = {1'b0, 18'h00003, 7'h20, 7'd4};
        r3 = {1'b1, 18'h00004, 7'h30, 7'd8};
        r4 = {1'b1, 18'h00005, 7'h40, 7'd8};
        tick(); req0_vld = 1'b1; req0_cmd = r0;
        req1_vld = 1'b1; req1_cmd = r1; #1;
        tick(); #1;
        n_tests++;
        if ({nfc_start, req1_rdy, nfc_cmd} !== {2'b10, r0}) begin
            n_fail++;
            $display("FAIL pair1_first got %b%b %h exp 10 %h",
                     nfc_start, req1_rdy, nfc_cmd, r0);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, nfc_start, nfc_cmd} !== {4'b1001, r1}) begin
            n_fail++;
            $display("FAIL pair1_second got %b%b%b%b %h exp 1001 %h",
                     cmp_vld, cmp_id, cmp_err, nfc_start, nfc_cmd, r1);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, nfc_start} !== 4'b1100) begin
            n_fail++;
            $display("FAIL pair1_cmp1 got %b%b%b%b exp 1100",
                     cmp_vld, cmp_id, cmp_err, nfc_start);
        end
        tick(); req0_vld = 1'b1; req0_cmd = r2; #1;
        tick(); #1;
        tick(); nfc_done = 1'b1; #1;
        tick(); req0_vld = 1'b1; req0_cmd = r3;
        req1_vld = 1'b1; req1_cmd = r4; #1;
        tick(); #1;
        n_tests++;
        if ({nfc_start, nfc_cmd} !== {1'b1, r4}) begin
            n_fail++;
            $display("FAIL pair2_first got %b %h exp 1 %h",
                     nfc_start, nfc_cmd, r4);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, nfc_start, nfc_cmd} !== {3'b111, r3}) begin
            n_fail++;
            $display("FAIL pair2_second got %b%b%b %h exp 111 %h",
                     cmp_vld, cmp_id, nfc_start, nfc_cmd, r3);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
    endtask

    task automatic test_collision();
        tick(); req0_vld = 1'b1; req0_cmd = {1'b0, 18'h00020, 7'h01, 7'd2}; #1;
        tick(); #1;
        tick(); nfc_done = 1'b1;
        req1_vld = 1'b1; req1_cmd = {1'b1, 18'h00021, 7'h02, 7'd0}; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, req0_rdy, req1_rdy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL collide_done got %b%b%b%b%b exp 10000",
                     cmp_vld, cmp_id, cmp_err, req0_rdy, req1_rdy);
        end
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, req0_rdy, req1_rdy} !== 5'b11111) begin
            n_fail++;
            $display("FAIL collide_rej got %b%b%b%b%b exp 11111",
                     cmp_vld, cmp_id, cmp_err, req0_rdy, req1_rdy);
        end
    endtask

    task automatic test_rst_busy();
        logic [32:0] re;
        re = {1'b1, 18'h00030, 7'h05, 7'd5};
        tick(); req0_vld = 1'b1; req0_cmd = {1'b0, 18'h2F, 7'h00, 7'd1}; #1;
        tick(); #1;
        tick(); #1;
        tick(); rst = 1'b1; #1;
        n_tests++;
        if ({busy, nfc_start, cmp_vld, cmp_id, cmp_err, req0_rdy, req1_rdy, nfc_cmd}
            !== {7'b0000011, 33'd0}) begin
            n_fail++;
            $display("FAIL rst_busy got %b%b%b%b%b%b%b %h exp 0000011 0",
                     busy, nfc_start, cmp_vld, cmp_id, cmp_err,
                     req0_rdy, req1_rdy, nfc_cmd);
        end
        tick(); rst = 1'b0; #1;
        tick(); req0_vld = 1'b1; req0_cmd = re; #1;
        tick(); #1;
        n_tests++;
        if ({nfc_start, req0_rdy, cmp_vld} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_wait_rdy got %b%b%b exp 000",
                     nfc_start, req0_rdy, cmp_vld);
        end
        tick(); #1;
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({nfc_start, cmp_vld, nfc_cmd} !== {2'b10, re}) begin
            n_fail++;
            $display("FAIL rst_restart got %b%b %h exp 10 %h",
                     nfc_start, cmp_vld, nfc_cmd, re);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_cmp got %b%b%b exp 100", cmp_vld, cmp_id, cmp_err);
        end
    endtask

    task automatic test_watchdog();
        logic seen;
        seen = 1'b0;
        tick(); req0_vld = 1'b1; req0_cmd = {1'b0, 18'h00040, 7'h00, 7'd3}; #1;
        tick(); #1;
`ifdef NFC_SCHED_WDT_EN
        for (int k = 1; k <= 100; k++) begin
            tick(); #1;
            if (cmp_vld === 1'b1 || busy !== 1'b1)
                seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL wdt_early got %b exp 0", seen);
        end
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err, busy} !== 4'b1010) begin
            n_fail++;
            $display("FAIL wdt_timeout got %b%b%b%b exp 1010",
                     cmp_vld, cmp_id, cmp_err, busy);
        end
        tick(); req0_vld = 1'b1; req0_cmd = {1'b0, 18'h41, 7'h00, 7'd1}; #1;
        tick(); #1;
        n_tests++;
        if ({nfc_start, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL wdt_wait_rdy got %b%b exp 00", nfc_start, busy);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
`else
        for (int k = 1; k <= 200; k++) begin
            tick(); #1;
            if (cmp_vld === 1'b1 || busy !== 1'b1)
                seen = 1'b1;
        end
        n_tests++;
        if ({seen, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL no_wdt_busy got %b%b exp 01", seen, busy);
        end
        tick(); nfc_done = 1'b1; #1;
        tick(); #1;
        n_tests++;
        if ({cmp_vld, cmp_id, cmp_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL no_wdt_cmp got %b%b%b exp 100",
                     cmp_vld, cmp_id, cmp_err);
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        nfc_done = 1'b0;
        test_reset();
        test_basic();
        test_reject();
        test_back_to_back();
        test_collision();
        test_rst_busy();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
